// File: rtl/mdu_hilo.sv
// mdu_hilo: multi-cycle multiply/divide unit that owns the HI/LO pair.
//   Requests arrive from the EX-stage ALU over a valid/ready handshake.
//   MULT/MULTU finish after MUL_STAGES edges. DIV/DIVU use a radix-2
//   restoring divider and finish after 34 edges: 1 prep, 32 iterations, 1 fix.
//   MTHI/MTLO write directly on the accept edge.
// Ports:
//   clk, resetn            clock, synchronous active-low reset
//   req_valid/req_ready    request handshake (ready only in IDLE)
//   req_op[2:0]            0 MULT,1 MULTU,2 DIV,3 DIVU,4 MTHI,5 MTLO,6-7 nop
//   req_a, req_b [31:0]    rs / rt operands
//   cancel                 flush: aborts an in-flight op, blocks accept
//   busy                   MUL or DIV in flight
//   done                   one-cycle pulse, new HI/LO visible this cycle
//   hi, lo [31:0]          architectural HI/LO
module mdu_hilo #(
  parameter int MUL_STAGES = 2
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [2:0]  req_op,
  input  logic [31:0] req_a,
  input  logic [31:0] req_b,
  input  logic        cancel,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  typedef enum logic [2:0] {
    S_IDLE, S_MUL, S_DIV_PRE, S_DIV_ITER, S_DIV_FIX
  } state_t;

  localparam logic [5:0] MUL_LAST = 6'(MUL_STAGES - 1);

  state_t      state_q;
  logic [31:0] a_q, b_q;
  logic        sgn_q;            // signed variant (MULT/DIV)
  logic [5:0]  cnt_q;
  logic [31:0] rem_q, quo_q, div_q;
  logic        qneg_q, rneg_q;
  logic [31:0] hi_q, lo_q;
  logic        done_q;

  logic        accept;
  logic [63:0] ma_d, mb_d, prod_d;
  logic [32:0] trial_d, diff_d;
  logic        take_d;

  assign busy      = (state_q != S_IDLE);
  assign req_ready = ~busy;
  assign accept    = req_valid & req_ready & ~cancel;
  assign done      = done_q;
  assign hi        = hi_q;
  assign lo        = lo_q;

  // Sign/zero extension to 64 bits makes the low 64 bits of one 64x64 multiply
  // correct for both MULT and MULTU. The MUL state only holds the result for
  // MUL_STAGES edges, so the multiplier can be retimed into that many stages.
  assign ma_d   = {{32{sgn_q & a_q[31]}}, a_q};
  assign mb_d   = {{32{sgn_q & b_q[31]}}, b_q};
  assign prod_d = ma_d * mb_d;

  // One restoring step. Because rem < divisor, a set bit 32 in the difference
  // can only mean a borrow, so it selects "restore".
  assign trial_d = {rem_q, quo_q[31]};
  assign diff_d  = trial_d - {1'b0, div_q};
  assign take_d  = ~diff_d[32];

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sgn_q   <= 1'b0;
      cnt_q   <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      div_q   <= '0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (busy && cancel) begin
        // A flush overrides every state, including the final write edge.
        state_q <= S_IDLE;
      end else begin
        case (state_q)
          S_IDLE: begin
            if (accept) begin
              a_q   <= req_a;
              b_q   <= req_b;
              sgn_q <= ~req_op[0];
              cnt_q <= '0;
              case (req_op)
                3'd0, 3'd1: state_q <= S_MUL;
                3'd2, 3'd3: state_q <= S_DIV_PRE;
                3'd4:       hi_q    <= req_a;
                3'd5:       lo_q    <= req_a;
                default:    ;
              endcase
            end
          end
          S_MUL: begin
            if (cnt_q == MUL_LAST) begin
              {hi_q, lo_q} <= prod_d;
              done_q       <= 1'b1;
              state_q      <= S_IDLE;
            end else begin
              cnt_q <= cnt_q + 6'd1;
            end
          end
          S_DIV_PRE: begin
            quo_q   <= (sgn_q & a_q[31]) ? -a_q : a_q;
            div_q   <= (sgn_q & b_q[31]) ? -b_q : b_q;
            rem_q   <= '0;
            qneg_q  <= sgn_q & (a_q[31] ^ b_q[31]);
            rneg_q  <= sgn_q & a_q[31];
            cnt_q   <= '0;
            state_q <= S_DIV_ITER;
          end
          S_DIV_ITER: begin
            rem_q <= take_d ? diff_d[31:0] : trial_d[31:0];
            quo_q <= {quo_q[30:0], take_d};
            cnt_q <= cnt_q + 6'd1;
            if (cnt_q == 6'd31) state_q <= S_DIV_FIX;
          end
          S_DIV_FIX: begin
            // Divide by zero returns all-ones / dividend regardless of sign.
            // 0x8000_0000 / -1 needs no special case: negating 0x8000_0000
            // gives 0x8000_0000 back.
            if (b_q == '0) begin
              lo_q <= '1;
              hi_q <= a_q;
            end else begin
              lo_q <= qneg_q ? -quo_q : quo_q;
              hi_q <= rneg_q ? -rem_q : rem_q;
            end
            done_q  <= 1'b1;
            state_q <= S_IDLE;
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_mdu_hilo.sv
module tb_mdu_hilo;
  localparam int MUL_STAGES = 2;
  localparam int DIV_LAT    = 34;

  logic        clk = 1'b0;
  logic        resetn, req_valid, req_ready, cancel, busy, done;
  logic [2:0]  req_op;
  logic [31:0] req_a, req_b, hi, lo;

  int errors = 0;
  int checks = 0;
  logic [31:0] m_hi, m_lo;

  mdu_hilo #(.MUL_STAGES(MUL_STAGES)) dut (
    .clk(clk), .resetn(resetn), .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_a(req_a), .req_b(req_b), .cancel(cancel),
    .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a, b, hi, lo;
  } vec_t;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Reference model: plain arithmetic, with the architectural special cases.
  function automatic void ref_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                                 inout logic [31:0] h, inout logic [31:0] l);
    longint sp;
    logic [63:0] up;
    int sa, sb;
    case (op)
      3'd0: begin sp = longint'($signed(a)) * longint'($signed(b)); {h, l} = 64'(sp); end
      3'd1: begin up = {32'b0, a} * {32'b0, b}; {h, l} = up; end
      3'd2, 3'd3: begin
        if (b == 32'd0) begin
          l = 32'hFFFF_FFFF; h = a;
        end else if (op == 3'd2) begin
          if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            l = a; h = 32'd0;
          end else begin
            sa = a; sb = b;
            l = sa / sb; h = sa % sb;
          end
        end else begin
          l = a / b; h = a % b;
        end
      end
      3'd4: h = a;
      3'd5: l = a;
      default: ;
    endcase
  endfunction

  // Issue one request, wait for completion, check latency and HI/LO.
  // Returns in the done cycle so the next call issues back-to-back.
  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] eh, input logic [31:0] el, input string nm);
    int n;
    chk({nm, " ready"}, {63'd0, req_ready}, 64'd1);
    req_valid = 1'b1; req_op = op; req_a = a; req_b = b;
    tick();
    req_valid = 1'b0; req_a = $urandom; req_b = $urandom;
    chk({nm, " done0"}, {63'd0, done}, 64'd0);
    if (op < 3'd4) begin
      chk({nm, " busy"}, {63'd0, busy}, 64'd1);
      n = 0;
      while (!done && n < 100) begin
        tick();
        n++;
      end
      chk({nm, " latency"}, 64'(n), (op < 3'd2) ? 64'(MUL_STAGES) : 64'(DIV_LAT));
    end
    chk({nm, " busy_end"}, {63'd0, busy}, 64'd0);
    chk({nm, " hi"}, {32'd0, hi}, {32'd0, eh});
    chk({nm, " lo"}, {32'd0, lo}, {32'd0, el});
    m_hi = eh; m_lo = el;
  endtask

  initial begin
    vec_t tbl[14];
    logic [31:0] eh, el, a, b;
    logic [2:0] op;
    int sel;
    logic seen;

    tbl[0]  = '{3'd0, 32'hFFFF_FFFE, 32'd3,        32'hFFFF_FFFF, 32'hFFFF_FFFA};
    tbl[1]  = '{3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001};
    tbl[2]  = '{3'd2, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, 32'hFFFF_FFFD};
    tbl[3]  = '{3'd3, 32'd7,         32'd2,        32'd1,         32'd3};
    tbl[4]  = '{3'd3, 32'h0000_1234, 32'd0,        32'h0000_1234, 32'hFFFF_FFFF};
    tbl[5]  = '{3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,        32'h8000_0000};
    tbl[6]  = '{3'd2, 32'd5,         32'd0,        32'd5,         32'hFFFF_FFFF};
    tbl[7]  = '{3'd2, 32'hFFFF_FFFB, 32'd0,        32'hFFFF_FFFB, 32'hFFFF_FFFF};
    tbl[8]  = '{3'd4, 32'hA5A5_A5A5, 32'd0,        32'hA5A5_A5A5, 32'hFFFF_FFFF};
    tbl[9]  = '{3'd5, 32'h5A5A_5A5A, 32'd0,        32'hA5A5_A5A5, 32'h5A5A_5A5A};
    tbl[10] = '{3'd6, 32'h1234_5678, 32'd9,        32'hA5A5_A5A5, 32'h5A5A_5A5A};
    tbl[11] = '{3'd2, 32'd7,         32'hFFFF_FFFE, 32'd1,        32'hFFFF_FFFD};
    tbl[12] = '{3'd0, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'd0};
    tbl[13] = '{3'd3, 32'hFFFF_FFFF, 32'd1,        32'd0,         32'hFFFF_FFFF};

    resetn = 1'b0; req_valid = 1'b0; req_op = 3'd0; req_a = 32'hDEAD_BEEF; req_b = 32'd1; cancel = 1'b0;
    tick(); tick();
    chk("reset hi", {32'd0, hi}, 64'd0);
    chk("reset lo", {32'd0, lo}, 64'd0);
    chk("reset busy", {63'd0, busy}, 64'd0);
    chk("reset done", {63'd0, done}, 64'd0);
    chk("reset ready", {63'd0, req_ready}, 64'd1);
    resetn = 1'b1;
    tick();

    for (int i = 0; i < 14; i++)
      run_op(tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].hi, tbl[i].lo, $sformatf("vec%0d", i));

    for (int i = 0; i < 40; i++) begin
      op  = 3'($urandom_range(0, 7));
      a   = ($urandom_range(0, 7) == 0) ? 32'h8000_0000 : $urandom;
      sel = $urandom_range(0, 7);
      b   = (sel == 0) ? 32'd0 : (sel == 1) ? 32'hFFFF_FFFF :
            (sel < 4) ? 32'($urandom_range(1, 100)) : $urandom;
      eh = m_hi; el = m_lo;
      ref_op(op, a, b, eh, el);
      run_op(op, a, b, eh, el, $sformatf("rnd%0d", i));
    end

    // Known HI/LO so aborted divides would visibly change them.
    run_op(3'd4, 32'h1111_1111, 32'd0, 32'h1111_1111, m_lo, "mthi");
    run_op(3'd5, 32'h2222_2222, 32'd0, 32'h1111_1111, 32'h2222_2222, "mtlo");

    // Cancel at iteration 10.
    req_valid = 1'b1; req_op = 3'd2; req_a = 32'd100; req_b = 32'd7;
    tick(); req_valid = 1'b0;
    tick();
    repeat (10) tick();
    cancel = 1'b1; tick(); cancel = 1'b0;
    chk("cxl10 busy", {63'd0, busy}, 64'd0);
    chk("cxl10 done", {63'd0, done}, 64'd0);
    seen = 1'b0;
    repeat (40) begin tick(); seen |= done; end
    chk("cxl10 no_done", {63'd0, seen}, 64'd0);
    chk("cxl10 hi", {32'd0, hi}, 64'h1111_1111);
    chk("cxl10 lo", {32'd0, lo}, 64'h2222_2222);

    // Cancel on the final write edge.
    req_valid = 1'b1; req_op = 3'd3; req_a = 32'd100; req_b = 32'd7;
    tick(); req_valid = 1'b0;
    repeat (DIV_LAT - 1) tick();
    chk("cxlend busy_before", {63'd0, busy}, 64'd1);
    cancel = 1'b1; tick(); cancel = 1'b0;
    chk("cxlend done", {63'd0, done}, 64'd0);
    chk("cxlend busy", {63'd0, busy}, 64'd0);
    chk("cxlend hi", {32'd0, hi}, 64'h1111_1111);
    chk("cxlend lo", {32'd0, lo}, 64'h2222_2222);

    // Cancel in IDLE blocks accept.
    req_valid = 1'b1; req_op = 3'd4; req_a = 32'hDEAD_0001; cancel = 1'b1;
    tick();
    chk("cxlidle mthi", {32'd0, hi}, 64'h1111_1111);
    req_op = 3'd2;
    tick();
    req_valid = 1'b0; cancel = 1'b0;
    chk("cxlidle div busy", {63'd0, busy}, 64'd0);
    tick();

    // Reset in the middle of a divide.
    req_valid = 1'b1; req_op = 3'd2; req_a = 32'd1000; req_b = 32'd3;
    tick(); req_valid = 1'b0;
    repeat (15) tick();
    resetn = 1'b0; tick();
    chk("rstdiv hi", {32'd0, hi}, 64'd0);
    chk("rstdiv lo", {32'd0, lo}, 64'd0);
    chk("rstdiv busy", {63'd0, busy}, 64'd0);
    chk("rstdiv done", {63'd0, done}, 64'd0);
    resetn = 1'b1; tick();
    run_op(3'd0, 32'd6, 32'd7, 32'd0, 32'd42, "post_rst");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
